// File: rtl/wb_queue.sv
// wb_queue: writeback FIFO between the execute/memory stage and the register
// file. Results arrive over valid/ready, drain one per cycle onto a registered
// write port, and expose a pending-register mask for hazard detection.
// Optional feature macro: WB_BYPASS_EN builds the forwarding lookup
// (fwd_hit*/fwd_data*). Without it the forwarding outputs are tied to 0.
module wb_queue #(
  parameter int DEPTH = 2,
  parameter int DW    = 8,
  parameter int AW    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_we,
  input  logic [AW-1:0]          in_reg,
  input  logic [DW-1:0]          in_data,
  input  logic                   flush,
  input  logic                   hold,
  output logic                   regwrite,
  output logic [AW-1:0]          write_reg,
  output logic [DW-1:0]          write_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [2**AW-1:0]       pending,
  input  logic [AW-1:0]          q_reg1,
  input  logic [AW-1:0]          q_reg2,
  output logic                   fwd_hit1,
  output logic                   fwd_hit2,
  output logic [DW-1:0]          fwd_data1,
  output logic [DW-1:0]          fwd_data2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] rg;
    logic [DW-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   tail_ptr;
  logic [DEPTH-1:0] entry_valid;
  logic            push;
  logic            pop;

  // Distance of a slot from the head, widened to compare against count.
  function automatic logic [CW-1:0] age_of(input logic [PW-1:0] idx,
                                           input logic [PW-1:0] head);
    logic [PW-1:0] d;
    d = idx - head;
    return {1'b0, d};
  endfunction

  // Full queue refuses input even if it pops this cycle: no pass-through.
  assign in_ready = !rst && !flush && (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0) && !hold && !flush;

  // Pointer and occupancy bookkeeping; flush and reset empty the queue.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PW'(1);
      if (pop)  head_ptr <= head_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage written at the tail on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; validity comes solely from
    // head/tail/count, so stale contents are never observed.
    if (push) mem[tail_ptr] <= '{we: in_we, rg: in_reg, data: in_data};
  end

  // Registered register-file write port, loaded from the popped head.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else if (pop) begin
      regwrite   <= mem[head_ptr].we;
      write_reg  <= mem[head_ptr].rg;
      write_data <= mem[head_ptr].data;
    end else begin
      regwrite   <= 1'b0;
    end
  end

  // Slot validity and the pending mask over queued register-writing entries.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    entry_valid = '0;
    pending     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = age_of(PW'(i), head_ptr) < count;
      if (entry_valid[i] && mem[i].we) pending[mem[i].rg] = 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  // Forwarding lookup: walk oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) begin
        if (mem[PW'(head_ptr + PW'(k))].we && mem[PW'(head_ptr + PW'(k))].rg == q_reg1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = mem[PW'(head_ptr + PW'(k))].data;
        end
        if (mem[PW'(head_ptr + PW'(k))].we && mem[PW'(head_ptr + PW'(k))].rg == q_reg2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = mem[PW'(head_ptr + PW'(k))].data;
        end
      end
    end
  end
`else
  // No bypass: consumers stall on pending alone.
  logic unused_fwd_lookup;
  assign unused_fwd_lookup = ^{q_reg1, q_reg2};
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif

endmodule
